// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory stream loader.
// Holds the loader state encoding, the byte/word geometry of the target RAM
// and the helper that turns a byte lane into a byte-enable mask.
package mem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    VERIFY_RD,
    VERIFY_CHK,
    DONE
  } state_e;

  // Mask covering lanes 0..lane, so lane 3 yields a full 4'hF.
  function automatic logic [WORD_BYTES-1:0] be_from_lane(input logic [1:0] lane);
    logic [WORD_BYTES:0] ones;
    ones = (5'd1 << (3'(lane) + 3'd1)) - 5'd1;
    return ones[WORD_BYTES-1:0];
  endfunction

endpackage

// File: rtl/mem_stream_loader_byte_packer.sv
// byte_packer: packs an accepted byte stream little-endian into 32-bit words.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   clear_i         drop any partially packed word (start of a new load)
//   accept_i        a byte is being accepted this cycle
//   data_i          the byte being accepted
//   last_i          the accepted byte is the final one of the transfer
//   lane_o          lane the next accepted byte will occupy
//   word_o          packed word including the byte on data_i at lane_o
//   be_o            byte-enable covering lanes 0..lane_o
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         accept_i,
  input  logic [BYTE_W-1:0]            data_i,
  input  logic                         last_i,
  output logic [1:0]                   lane_o,
  output logic [WORD_BYTES*BYTE_W-1:0] word_o,
  output logic [WORD_BYTES-1:0]        be_o
);

  logic [1:0]                   lane_q, lane_d;
  logic [WORD_BYTES*BYTE_W-1:0] word_q, word_d;
  logic [WORD_BYTES*BYTE_W-1:0] merged;
  logic                         wordDone;

  // The stored word is kept zero above the current lane, so a partial final
  // word comes out with its unused bytes already cleared.
  always_comb begin
    merged = word_q;
    merged[lane_q*BYTE_W +: BYTE_W] = data_i;
  end

  assign wordDone = (lane_q == 2'd3) || last_i;

  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = 2'd0;
      word_d = '0;
    end else if (accept_i) begin
      if (wordDone) begin
        lane_d = 2'd0;
        word_d = '0;
      end else begin
        lane_d = lane_q + 2'd1;
        word_d = merged;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lane_q <= 2'd0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign lane_o = lane_q;
  assign word_o = merged;
  assign be_o   = be_from_lane(lane_q);

endmodule

// File: rtl/mem_stream_loader.sv
// mem_stream_loader: loads a valid/ready byte stream into the on-chip RAM as
// little-endian 32-bit words starting at a programmable base word address,
// optionally reads the region back to confirm an additive byte checksum, and
// reports completion/status to the control processor.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, base_addr           begin a load (IDLE only), first word address
//   in_valid/in_ready/in_data/in_last   byte stream handshake
//   mem_*                      RAM port (1-cycle read latency), mem_clken tied 1
//   busy, done                 not IDLE, one-cycle completion pulse
//   error, verify_ok           overflow flag, read-back checksum result
//   word_count, checksum       words written, sum of accepted bytes
module mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH     = 10024,
  parameter int ADDR_W    = 14,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              verify_ok,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   wc_q;
  logic [31:0]       checksum_q;
  logic              error_q;
  logic              verifyOk_q;
  logic              busy_q;
  logic              done_q;
  logic              inReady_q;
  logic              cs_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [3:0]        lastBe_q;
  logic [ADDR_W:0]   rdIdx_q;
  logic              rdValid_q;
  logic [3:0]        rdBe_q;
  logic [31:0]       verSum_q;

  logic              accept;
  logic              packClear;
  logic [1:0]        packLane;
  logic [31:0]       packWord;
  logic [3:0]        packBe;
  logic [ADDR_W:0]   wrAddr;
  logic              wrLegal;
  logic [ADDR_W-1:0] rdAddr;
  logic [3:0]        issueBe;
  logic [31:0]       readSum;

  assign accept    = in_valid & inReady_q;
  assign packClear = start && (state_q == IDLE);

  byte_packer u_packer (
    .clk_i    (clk),
    .reset_i  (reset),
    .clear_i  (packClear),
    .accept_i (accept),
    .data_i   (in_data),
    .last_i   (in_last),
    .lane_o   (packLane),
    .word_o   (packWord),
    .be_o     (packBe)
  );

  // Write address is formed one bit wider than the RAM address so that the
  // overflow test cannot be fooled by wrap-around.
  assign wrAddr  = {1'b0, base_q} + wc_q;
  assign wrLegal = wrAddr < DEPTH_W;

  // Read-back walks the written words; only the final word can be partial.
  assign rdAddr  = base_q + rdIdx_q[ADDR_W-1:0];
  assign issueBe = ((rdIdx_q + ONE_W) == wc_q) ? lastBe_q : {WORD_BYTES{1'b1}};

  // Byte sum of the returning read word, limited to the lanes that were written.
  always_comb begin
    readSum = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (rdBe_q[k]) begin
        readSum = readSum + 32'(mem_readdata[k*BYTE_W +: BYTE_W]);
      end
    end
  end

  // Main controller: every output is registered here. rdValid_q/rdBe_q delay
  // the read strobe by one cycle to line up with the RAM's read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      wc_q       <= '0;
      checksum_q <= '0;
      error_q    <= 1'b0;
      verifyOk_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inReady_q  <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      lastBe_q   <= '0;
      rdIdx_q    <= '0;
      rdValid_q  <= 1'b0;
      rdBe_q     <= '0;
      verSum_q   <= '0;
    end else begin
      rdValid_q <= cs_q & ~we_q;
      rdBe_q    <= be_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            base_q     <= base_addr;
            wc_q       <= '0;
            checksum_q <= '0;
            error_q    <= 1'b0;
            verifyOk_q <= 1'b0;
            busy_q     <= 1'b1;
            inReady_q  <= 1'b1;
            rdIdx_q    <= '0;
            verSum_q   <= '0;
          end
        end
        LOAD: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          if (accept) begin
            checksum_q <= checksum_q + 32'(in_data);
            // A completed word, or the last byte on any lane, produces a write
            // in the following cycle unless it would land past the RAM end.
            if ((packLane == 2'd3) || in_last) begin
              if (wrLegal) begin
                cs_q    <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= wrAddr[ADDR_W-1:0];
                be_q    <= packBe;
                wdata_q <= packWord;
                wc_q    <= wc_q + ONE_W;
              end else begin
                error_q <= 1'b1;
              end
            end
            if (in_last) begin
              lastBe_q  <= packBe;
              inReady_q <= 1'b0;
              state_q   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          if ((VERIFY_EN != 0) && !error_q) begin
            state_q <= VERIFY_RD;
          end else begin
            verifyOk_q <= (VERIFY_EN == 0) && !error_q;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        VERIFY_RD: begin
          if (rdValid_q) begin
            verSum_q <= verSum_q + readSum;
          end
          if (rdIdx_q < wc_q) begin
            cs_q    <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= rdAddr;
            be_q    <= issueBe;
            rdIdx_q <= rdIdx_q + ONE_W;
          end else begin
            cs_q    <= 1'b0;
            state_q <= VERIFY_CHK;
          end
        end
        VERIFY_CHK: begin
          // Wait for the final read word to be folded in before comparing.
          if (rdValid_q) begin
            verSum_q <= verSum_q + readSum;
          end else begin
            verifyOk_q <= (verSum_q == checksum_q);
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = inReady_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = wdata_q;
  assign mem_clken      = 1'b1;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign verify_ok      = verifyOk_q;
  assign word_count     = wc_q;
  assign checksum       = checksum_q;

endmodule

// File: tb/tb_mem_stream_loader.sv
// Testbench for mem_stream_loader: drives byte transfers, models the RAM,
// and compares every write and the final status against a transfer-level model.
module tb_mem_stream_loader;

  localparam int DEPTH  = 10024;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              in_last;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              verify_ok;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;

  mem_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .VERIFY_EN(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .verify_ok      (verify_ok),
    .word_count     (word_count),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          doneCount;
  wr_t         expQ[$];
  wr_t         obsQ[$];
  logic [7:0]  xfer[64];
  logic        corrupt = 1'b0;
  logic [ADDR_W-1:0] corruptAddr = '0;
  logic [31:0] ram[DEPTH];
  logic        ramInit = 1'b0;

  int          expWc;
  logic [31:0] expSum;
  bit          expErr;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // RAM with one-cycle read latency; optionally flips bit 0 of one word on read.
  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
      ramInit <= 1'b1;
    end else if (mem_chipselect && (int'(mem_address) < DEPTH)) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address] ^ ((corrupt && mem_address == corruptAddr) ? 32'h1 : 32'h0);
      end
    end
  end

  // Every-cycle compare of RAM writes and handshake outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("mem_clken", mem_clken, 1);
      if (!busy) checkOutput("in_ready_idle", in_ready, 0);
      if (done) doneCount++;
      if (mem_chipselect && mem_write) begin
        obsQ.push_back('{mem_address, mem_writedata, mem_byteenable});
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h be 0x%0h, required none",
                   mem_address, mem_writedata, mem_byteenable);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          checkOutput("write_addr", mem_address, e.addr);
          checkOutput("write_data", mem_writedata, e.data);
          checkOutput("write_be", mem_byteenable, e.be);
        end
      end
    end
  end

  // Transfer-level model: words are consecutive groups of 4 bytes, little-endian.
  task automatic modelTransfer(input int base, input int n);
    int nWords;
    expWc  = 0;
    expSum = 0;
    expErr = 0;
    for (int i = 0; i < n; i++) expSum = expSum + 32'(xfer[i]);
    nWords = (n + 3) / 4;
    for (int w = 0; w < nWords; w++) begin
      if (base + w >= DEPTH) begin
        expErr = 1;
      end else begin
        wr_t e;
        e.addr = ADDR_W'(base + w);
        e.data = '0;
        e.be   = '0;
        for (int b = 0; b < 4; b++) begin
          if (4*w + b < n) begin
            e.data[b*8 +: 8] = xfer[4*w + b];
            e.be[b] = 1'b1;
          end
        end
        expQ.push_back(e);
        expWc++;
      end
    end
  endtask

  task automatic applyStimulus(input int base, input int n, input int gapPct, input int stopAfter);
    int idx = 0;
    int budget = 0;
    logic rdy;
    @(negedge clk);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (idx < stopAfter && budget < 8*n + 100) begin
      if (int'($urandom_range(0, 99)) < gapPct) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = xfer[idx];
        in_last  = (idx == n - 1);
      end
      rdy = in_ready;
      checkOutput("in_ready_load", in_ready, 1);
      @(negedge clk);
      if (in_valid && rdy) idx++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("bytes_accepted", idx, stopAfter);
    if (stopAfter == n) checkOutput("in_ready_after_last", in_ready, 0);
  endtask

  task automatic runTest(input int base, input int n, input int gapPct, input logic corr);
    int waitCyc = 0;
    bit expOk;
    corrupt     = corr;
    corruptAddr = ADDR_W'(base + 1);
    doneCount   = 0;
    expQ.delete();
    obsQ.delete();
    modelTransfer(base, n);
    expOk = !expErr && !(corr && expWc >= 2);
    applyStimulus(base, n, gapPct, n);
    while (!done && waitCyc < 300) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("done_seen", done, 1);
    @(negedge clk);
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("done_low_after", done, 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("word_count", word_count, expWc);
    checkOutput("checksum", checksum, expSum);
    checkOutput("error", error, expErr);
    checkOutput("verify_ok", verify_ok, expOk);
    checkOutput("writes_pending", expQ.size(), 0);
    corrupt = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("reset_flags", {in_ready, busy, done, error, verify_ok, mem_chipselect, mem_write}, 0);
    checkOutput("reset_be", mem_byteenable, 0);
    checkOutput("reset_addr", mem_address, 0);
    checkOutput("reset_wdata", mem_writedata, 0);
    checkOutput("reset_word_count", word_count, 0);
    checkOutput("reset_checksum", checksum, 0);
    checkOutput("reset_clken", mem_clken, 1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, n, gap;
    logic corr;
    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Two full words from base 0x10.
    for (int i = 0; i < 8; i++) xfer[i] = 8'(i + 1);
    runTest(16, 8, 0, 1'b0);
    checkOutput("t1_word_count", word_count, 2);
    checkOutput("t1_checksum", checksum, 32'h24);
    checkOutput("t1_nwrites", obsQ.size(), 2);
    if (obsQ.size() == 2) begin
      checkOutput("t1_w0", obsQ[0], {14'h0010, 32'h04030201, 4'hF});
      checkOutput("t1_w1", obsQ[1], {14'h0011, 32'h08070605, 4'hF});
    end

    // Partial final word on lane 0.
    xfer[0] = 8'hAA; xfer[1] = 8'hBB; xfer[2] = 8'hCC; xfer[3] = 8'hDD; xfer[4] = 8'hEE;
    runTest(0, 5, 0, 1'b0);
    checkOutput("t2_checksum", checksum, 32'h3FC);
    checkOutput("t2_verify_ok", verify_ok, 1);
    checkOutput("t2_nwrites", obsQ.size(), 2);
    if (obsQ.size() == 2) checkOutput("t2_w1", obsQ[1], {14'h0001, 32'h000000EE, 4'b0001});

    // Overflow past the last RAM word.
    for (int i = 0; i < 8; i++) xfer[i] = 8'(i + 1);
    runTest(DEPTH - 1, 8, 0, 1'b0);
    checkOutput("t3_error", error, 1);
    checkOutput("t3_verify_ok", verify_ok, 0);
    checkOutput("t3_word_count", word_count, 1);
    checkOutput("t3_nwrites", obsQ.size(), 1);

    // Gapped stream of 12 bytes.
    for (int i = 0; i < 12; i++) xfer[i] = 8'($urandom);
    runTest(64, 12, 40, 1'b0);
    checkOutput("t4_nwrites", obsQ.size(), 3);

    // Corrupted read-back of word 1.
    for (int i = 0; i < 8; i++) xfer[i] = 8'($urandom);
    runTest(128, 8, 0, 1'b1);
    checkOutput("t5_verify_ok", verify_ok, 0);
    checkOutput("t5_error", error, 0);

    // Reset in the middle of a load, then a clean 4-byte load.
    for (int i = 0; i < 10; i++) xfer[i] = 8'($urandom);
    expQ.delete();
    doneCount = 0;
    modelTransfer(200, 4);
    applyStimulus(200, 10, 0, 6);
    checkOutput("t6_first_word_written", expQ.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    checkResetState();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) xfer[i] = 8'($urandom);
    runTest(300, 4, 0, 1'b0);
    checkOutput("t6_word_count", word_count, 1);

    // Randomized transfers, including bases at and past the RAM end.
    for (int t = 0; t < 20; t++) begin
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) xfer[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) base = DEPTH - int'($urandom_range(0, 6));
      else base = int'($urandom_range(0, 500));
      gap = int'($urandom_range(0, 50));
      corr = ($urandom_range(0, 2) == 0);
      runTest(base, n, gap, corr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
